a0_uart_tx: RTL and testbench
=============================

A0_UART_TX -- requirements
Module: a0_uart_tx

Interface
REQ-001 Parameters SHALL be: CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535); FIFO_DEPTH, default 4, byte-FIFO entries (power of 2, 2..16).
REQ-002 Ports SHALL be exactly, in this order:
- clk_i  input  1  single clock; all state changes on the rising edge.
- rst_ni  input  1  synchronous reset, active-low.
- data_i  input  8  CPU output byte (a0[7:0]), sampled every cycle.
- tx_o  output  1  serial line, idle high.
- busy_o  output  1  high while a frame is in flight or the FIFO is non-empty.
- overflow_o  output  1  sticky, set when a byte is dropped.

Function
REQ-003 Change detection SHALL use a register prev holding the last sampled data_i; a push SHALL be requested in any cycle where data_i != prev, and prev SHALL load data_i every cycle.
REQ-004 A requested push SHALL write data_i into the FIFO at the same edge that updates prev.
REQ-005 The FIFO SHALL be first-in first-out, with pointer wrap-around modulo FIFO_DEPTH and a count of 0..FIFO_DEPTH.
REQ-006 A push while full SHALL be accepted only if a pop occurs in the same cycle; otherwise the byte SHALL be dropped, overflow_o SHALL be set at that edge, and FIFO contents SHALL be unchanged.
REQ-007 Simultaneous push and pop when non-full SHALL leave the count unchanged. Simultaneous push and pop when empty is impossible (pop requires non-empty).
REQ-008 The TX FSM SHALL have states IDLE, START, DATA, STOP, with a bit-timer counting 0..CLKS_PER_BIT-1 and a bit index 0..7.
REQ-009 IDLE: tx_o=1. If the FIFO is non-empty: pop the head into the shift register, clear the timer, go to START.
REQ-010 START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-011 DATA: tx_o = shift[bit index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
REQ-012 STOP: tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE. This gives 10*CLKS_PER_BIT cycles per frame.
REQ-013 Back-to-back frames: the IDLE cycle between STOP and the next START SHALL be exactly one cycle, so frame spacing is 10*CLKS_PER_BIT+1 cycles.
REQ-014 tx_o SHALL be registered. For a data_i change sampled at edge k, tx_o SHALL go low after edge k+1 when the FSM was IDLE with an empty FIFO.
REQ-015 busy_o SHALL be combinational: (state != IDLE) or (count != 0).
REQ-016 overflow_o SHALL clear only on reset.

Reset
REQ-017 While rst_ni=0 at an edge, the block SHALL set: state=IDLE, tx_o=1, prev=8'h00, FIFO count and pointers=0, timer and bit index=0, overflow_o=0.
REQ-018 Reset asserted mid-frame SHALL abort the frame; tx_o SHALL be 1 after that edge and queued bytes SHALL be discarded.
REQ-019 Because prev resets to 0, a nonzero data_i in the first cycle after reset SHALL be pushed.

Structure
REQ-020 The package uart_pkg SHALL hold the FSM state enum (tx_state_t) and the frame-length constant (10 bits).
REQ-021 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count). The FSM and change detector SHALL stay in a0_uart_tx.
REQ-022 The block SHALL connect outside the CPU top, with data_i driven from data_out_o. It SHALL NOT drive any CPU signal.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-023 Reset, then data_i 00->55 -> tx_o low one edge after the push, then bit levels 0 | 1,0,1,0,1,0,1,0 | 1, each held 4 cycles; busy_o low after 40 frame cycles.
REQ-024 data_i steps 01,02,03 on consecutive cycles -> three frames in order 01,02,03, spaced 41 cycles; overflow_o stays 0.
REQ-025 Six distinct changes on consecutive cycles while idle -> the first byte is popped, four are queued and the sixth is dropped; overflow_o=1 and 5 frames are sent.
REQ-026 With the FIFO full, a new value arrives in the same cycle as an IDLE pop -> the push is accepted, count stays 4 and overflow_o stays 0.
REQ-027 rst_ni pulsed low during DATA bit 3 with 2 bytes queued -> tx_o=1 after the edge; busy_o=0 and no further frames if data_i is held at 00.
REQ-028 data_i held constant at A5 for 100 cycles after its single push -> exactly one frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the a0 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // One start bit, eight data bits, one stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth and a combinational head read.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  always_comb begin
    rd_en    = pop && (count_q != '0);
    wr_en    = push && ((count_q != CW'(DEPTH)) || rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, the write slot equals the head slot; the head is read before it is overwritten.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/a0_uart_tx.sv
// Byte-change-triggered UART transmitter: every change on data_i queues that byte
// and the FSM sends it as an 8N1 frame on tx_o.
module a0_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       overflow_o
);
  localparam int          CW       = $clog2(FIFO_DEPTH + 1);
  localparam int          BW       = $clog2(DATA_BITS);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t      state_q, state_d;
  logic           tx_q, tx_d;
  logic [15:0]    timer_q, timer_d;
  logic [BW-1:0]  bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     prev_q, prev_d;
  logic           overflow_q, overflow_d;

  logic           push, pop;
  logic [7:0]     fifo_dout;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .din    (data_i),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    prev_d     = data_i;
    push       = (data_i != prev_q);
    pop        = (state_q == ST_IDLE) && !fifo_empty;
    overflow_d = overflow_q | (push & fifo_full & ~pop);

    state_d   = state_q;
    tx_d      = tx_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    // tx_d is the line level for the cycle after this edge, so tx_o stays registered.
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = fifo_dout;
          timer_d = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (bit_idx_q == BW'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
            tx_d      = shift_q[bit_idx_d];
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      prev_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = (state_q != ST_IDLE) || (fifo_count != '0);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_a0_uart_tx.sv
// Randomized scoreboard bench for a0_uart_tx: a timing-level model predicts accepted
// bytes and frame start edges; a line monitor decodes tx_o and compares.
module tb_a0_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, busy, ovf;

  always #5 clk = ~clk;

  a0_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .data_i     (data),
    .tx_o       (tx),
    .busy_o     (busy),
    .overflow_o (ovf)
  );

  typedef struct {
    logic [7:0] b;
    int         pe;
    int         se;
  } frame_t;

  int         passed = 0;
  int         total  = 0;
  int         cyc    = 0;
  int         reset_e = 0;
  int         last_start = -100000;
  logic [7:0] prev_m = 8'h00;
  logic       ovf_m = 1'b0;
  logic       busy_m = 1'b0;
  frame_t     acc[$];
  frame_t     exp_q[$];
  logic [7:0] decoded[$];
  bit         in_frame = 0;
  logic       samp [FRAME];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference model: a byte pushed at edge e starts at the later of e+1 and
  // previous start + FRAME + 1; it occupies the FIFO until its start edge.
  always @(posedge clk) begin : model
    int     cnt;
    bit     popping;
    int     s;
    frame_t f;
    cyc = cyc + 1;
    if (!rst_n) begin
      acc.delete();
      exp_q.delete();
      prev_m     = 8'h00;
      ovf_m      = 1'b0;
      last_start = -100000;
      reset_e    = cyc;
    end else begin
      while (acc.size() > 0 && acc[0].se + FRAME <= cyc) void'(acc.pop_front());
      if (data !== prev_m) begin
        cnt = 0;
        popping = 0;
        foreach (acc[i]) begin
          if (acc[i].se >= cyc) cnt++;
          if (acc[i].se == cyc) popping = 1;
        end
        if (cnt < DEPTH || popping) begin
          s = cyc + 1;
          if (last_start + FRAME + 1 > s) s = last_start + FRAME + 1;
          f.b = data; f.pe = cyc; f.se = s;
          acc.push_back(f);
          exp_q.push_back(f);
          last_start = s;
        end else begin
          ovf_m = 1'b1;
        end
      end
      prev_m = data;
    end
    busy_m = (acc.size() != 0);
  end

  // Line monitor: decodes each frame from tx_o and checks it against the scoreboard.
  initial begin : monitor
    int         fs;
    logic [7:0] b;
    bit         shape_ok;
    frame_t     e;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        check("busy", busy, busy_m);
        check("overflow", ovf, ovf_m);
        if (in_frame && reset_e >= fs) in_frame = 0;
        if (in_frame) begin
          samp[cyc - fs] = tx;
          if (cyc - fs == FRAME - 1) begin
            in_frame = 0;
            shape_ok = (samp[0] === 1'b0) && (samp[FRAME - CPB] === 1'b1);
            for (int j = 0; j < 10; j++)
              for (int t = 1; t < CPB; t++)
                if (samp[j * CPB + t] !== samp[j * CPB]) shape_ok = 0;
            for (int i = 0; i < 8; i++) b[i] = samp[(i + 1) * CPB];
            decoded.push_back(b);
            check("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("frame_byte", b, e.b);
              check("frame_start", fs, e.se);
            end
            check("frame_shape", shape_ok, 1);
            $display("frame byte=%02h start_edge=%0d", b, fs);
          end
        end else if (tx === 1'b0) begin
          in_frame = 1;
          fs = cyc;
          samp[0] = tx;
        end
      end
    end
  end

  task automatic do_reset(input logic [7:0] d_after);
    @(negedge clk);
    rst_n = 1'b0;
    data  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    data  = d_after;
  endtask

  task automatic step(input logic [7:0] d);
    @(negedge clk);
    data = d;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((acc.size() != 0 || in_frame) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_timeout"}, n < 3000, 1);
    repeat (3) @(negedge clk);
    check({tag, "_pending_frames"}, exp_q.size(), 0);
  endtask

  task automatic expect_bytes(input string tag, input int n0, input logic [7:0] want[$]);
    logic [31:0] got;
    check({tag, "_frame_count"}, decoded.size() - n0, want.size());
    foreach (want[i]) begin
      got = (n0 + i < decoded.size()) ? {24'h0, decoded[n0 + i]} : 32'hdead;
      check({tag, "_byte"}, got, {24'h0, want[i]});
    end
  endtask

  initial begin : stim
    int         n0;
    logic [7:0] wq[$];

    // Reset state, single 0x55 frame pushed in the first cycle after reset.
    do_reset(8'h55);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", ovf, 1'b0);
    n0 = decoded.size();
    @(negedge clk);
    check("tx_idle_at_push", tx, 1'b1);
    check("busy_after_push", busy, 1'b1);
    @(negedge clk);
    check("tx_start_low", tx, 1'b0);
    wait_idle("s55");
    wq = {8'h55};
    expect_bytes("s55", n0, wq);

    // Three consecutive changes: frames in order, no overflow.
    do_reset(8'h00);
    n0 = decoded.size();
    step(8'h01); step(8'h02); step(8'h03);
    wait_idle("seq3");
    wq = {8'h01, 8'h02, 8'h03};
    expect_bytes("seq3", n0, wq);
    check("seq3_overflow", ovf, 1'b0);

    // Six changes while idle: sixth byte is dropped.
    do_reset(8'h00);
    n0 = decoded.size();
    step(8'h11); step(8'h22); step(8'h33); step(8'h44); step(8'h55); step(8'h66);
    wait_idle("six");
    wq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    expect_bytes("six", n0, wq);
    check("six_overflow", ovf, 1'b1);

    // Full FIFO, push lands on the IDLE pop edge and is accepted.
    do_reset(8'hA1);
    n0 = decoded.size();
    step(8'hB1); step(8'hB2); step(8'hB3); step(8'hB4);
    repeat (37) @(negedge clk);
    step(8'hC7);
    @(negedge clk);
    check("popfull_overflow", ovf, 1'b0);
    wait_idle("popfull");
    wq = {8'hA1, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC7};
    expect_bytes("popfull", n0, wq);
    check("popfull_overflow_end", ovf, 1'b0);

    // Reset during DATA bit 3 with two bytes queued.
    do_reset(8'h3C);
    step(8'h4D); step(8'h5E);
    repeat (15) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    data  = 8'h00;
    @(negedge clk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    n0 = decoded.size();
    repeat (150) @(negedge clk);
    check("midrst_no_frames", decoded.size() - n0, 0);
    check("midrst_busy_later", busy, 1'b0);

    // Constant input after a single push yields exactly one frame.
    do_reset(8'hA5);
    n0 = decoded.size();
    repeat (100) @(negedge clk);
    wait_idle("hold");
    wq = {8'hA5};
    expect_bytes("hold", n0, wq);

    // Random byte stream, checked by model and monitor.
    do_reset(8'h00);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) step(8'($urandom_range(0, 255)));
      else step(data);
    end
    wait_idle("random");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: got running want finished (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
